// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and
// PC-related constants.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } ifetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the synchronous ROM word
// address, pairs each ROM read with its PC and presents it to decode over
// valid/ready. Redirects take effect with zero bubble; stalls re-read the
// held address so rom_data stays stable.
// Optional feature macro: IFETCH_ALIGN_CHK_EN (misaligned redirect raises
// inst_adel and halts fetch until the next redirect).
module inst_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    output logic        inst_adel,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    ifetch_state_e state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_adel_q, resp_adel_d;

    logic [31:0]   redirect_tgt;
    logic          redirect_misaligned;
    logic          advance;
    logic [31:0]   addr_pc;

    // Redirect target and its alignment status for the active build.
`ifdef IFETCH_ALIGN_CHK_EN
    assign redirect_tgt        = redirect_pc;
    assign redirect_misaligned = |redirect_pc[1:0];
`else
    assign redirect_tgt        = redirect_pc & PC_ALIGN_MASK;
    assign redirect_misaligned = 1'b0;
`endif

    // Handshake, output and ROM address selection.
    always_comb begin
        advance    = (state_q != S_HALT) && (!resp_valid_q || inst_ready);
        inst_valid = resp_valid_q && !redirect_valid;
        inst_pc    = resp_pc_q;
        inst       = resp_adel_q ? NOP_INST : rom_data;

        if (redirect_valid) begin
            addr_pc = redirect_tgt;
        end else if (state_q == S_BOOT || advance) begin
            addr_pc = fetch_pc_q;
        end else begin
            // Re-read the held PC so the ROM keeps presenting the same word.
            addr_pc = resp_pc_q;
        end
        rom_addr = addr_pc >> 2;
    end

`ifdef IFETCH_ALIGN_CHK_EN
    assign inst_adel = resp_adel_q;
`else
    assign inst_adel = 1'b0;
`endif

    // Next-state logic: redirect first, then per-state fetch progress.
    always_comb begin
        // NOTE: every signal gets a hold default up front so no path through
        // the case/if tree leaves it unassigned, which would infer a latch.
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        resp_adel_d  = resp_adel_q;

        if (redirect_valid) begin
            resp_pc_d    = redirect_tgt;
            resp_valid_d = 1'b1;
            fetch_pc_d   = redirect_tgt + PC_INC;
            resp_adel_d  = redirect_misaligned;
            state_d      = redirect_misaligned ? S_HALT : S_RUN;
        end else begin
            unique case (state_q)
                S_BOOT, S_RUN: begin
                    if (state_q == S_BOOT || advance) begin
                        resp_pc_d    = fetch_pc_q;
                        resp_valid_d = 1'b1;
                        resp_adel_d  = 1'b0;
                        fetch_pc_d   = fetch_pc_q + PC_INC;
                        state_d      = S_RUN;
                    end
                end
                S_HALT: begin
                    // Faulting pair leaves once decode takes it; fetch stays off.
                    if (inst_valid && inst_ready) begin
                        resp_valid_d = 1'b0;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    // State registers with synchronous reset taking precedence over all else.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= S_BOOT;
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_adel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_adel_q  <= resp_adel_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: plays the parent with a synchronous ROM
// whose contents are a fixed function of the word address.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_adel;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int vectors;
    int miscompares;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst           (inst),
        .inst_adel      (inst_adel),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM word contents as a function of the word address.
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return a ^ 32'h5EED_0000 ^ {a[15:0], 16'h0};
    endfunction

    // One-cycle-latency synchronous ROM.
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic apply_reset();
        rst = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst_adel, rom_addr} !== {1'b0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_out: got v=%b adel=%b addr=%h, want v=0 adel=0 addr=0",
                     inst_valid, inst_adel, rom_addr);
        end
        rst = 1'b0;
        inst_ready = 1'b1;
        #1;
        vectors++;
        if ({inst_valid, rom_addr} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL boot_cycle0: got v=%b addr=%h, want v=0 addr=0", inst_valid, rom_addr);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0, rom_fn(32'h0)}) begin
            miscompares++;
            $display("FAIL boot_cycle1: got v=%b pc=%h inst=%h, want v=1 pc=0 inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h0));
        end
    endtask

    task automatic test_stream();
        apply_reset();
        inst_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, 32'(4 * i), rom_fn(32'(i))}) begin
                miscompares++;
                $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h, want v=1 pc=%h inst=%h",
                         i, inst_valid, inst_pc, inst, 32'(4 * i), rom_fn(32'(i)));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({inst_valid, inst_pc, inst, rom_addr} !== {1'b1, 32'h8, rom_fn(32'h2), 32'h2}) begin
                miscompares++;
                $display("FAIL stall[%0d]: got v=%b pc=%h inst=%h addr=%h, want v=1 pc=8 inst=%h addr=2",
                         i, inst_valid, inst_pc, inst, rom_addr, rom_fn(32'h2));
            end
            @(negedge clk);
        end
        inst_ready = 1'b1;
        #1;
        vectors++;
        if ({inst_valid, inst_pc, rom_addr} !== {1'b1, 32'h8, 32'h3}) begin
            miscompares++;
            $display("FAIL stall_release: got v=%b pc=%h addr=%h, want v=1 pc=8 addr=3",
                     inst_valid, inst_pc, rom_addr);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'hC, rom_fn(32'h3)}) begin
            miscompares++;
            $display("FAIL stall_next: got v=%b pc=%h inst=%h, want v=1 pc=c inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h3));
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #1;
        vectors++;
        if ({inst_valid, inst_pc, rom_addr} !== {1'b0, 32'h4, 32'h10}) begin
            miscompares++;
            $display("FAIL redir_cycle: got v=%b pc=%h addr=%h, want v=0 pc=4 addr=10",
                     inst_valid, inst_pc, rom_addr);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h40, rom_fn(32'h10)}) begin
            miscompares++;
            $display("FAIL redir_target: got v=%b pc=%h inst=%h, want v=1 pc=40 inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h10));
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h44, rom_fn(32'h11)}) begin
            miscompares++;
            $display("FAIL redir_follow: got v=%b pc=%h inst=%h, want v=1 pc=44 inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h11));
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'hFFFF_FFFC, rom_fn(32'h3FFF_FFFF)}) begin
            miscompares++;
            $display("FAIL wrap_top: got v=%b pc=%h inst=%h, want v=1 pc=fffffffc inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h3FFF_FFFF));
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0, rom_fn(32'h0)}) begin
            miscompares++;
            $display("FAIL wrap_zero: got v=%b pc=%h inst=%h, want v=1 pc=0 inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h0));
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect_pc = 32'h200;
        #1;
        vectors++;
        if ({inst_valid, rom_addr} !== {1'b0, 32'h80}) begin
            miscompares++;
            $display("FAIL b2b_second: got v=%b addr=%h, want v=0 addr=80", inst_valid, rom_addr);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h200, rom_fn(32'h80)}) begin
            miscompares++;
            $display("FAIL b2b_target: got v=%b pc=%h inst=%h, want v=1 pc=200 inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h80));
        end
        @(negedge clk);
        inst_ready = 1'b1;
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h200, rom_fn(32'h80)}) begin
            miscompares++;
            $display("FAIL b2b_held: got v=%b pc=%h inst=%h, want v=1 pc=200 inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h80));
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h204, rom_fn(32'h81)}) begin
            miscompares++;
            $display("FAIL b2b_follow: got v=%b pc=%h inst=%h, want v=1 pc=204 inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h81));
        end
    endtask

    task automatic test_align();
        @(negedge clk);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
`ifdef IFETCH_ALIGN_CHK_EN
        vectors++;
        if ({inst_valid, inst_pc, inst, inst_adel} !== {1'b1, 32'h42, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL adel_pair: got v=%b pc=%h inst=%h adel=%b, want v=1 pc=42 inst=0 adel=1",
                     inst_valid, inst_pc, inst, inst_adel);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (inst_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL adel_halt[%0d]: got v=%b, want v=0", i, inst_valid);
            end
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst, inst_adel} !== {1'b1, 32'h80, rom_fn(32'h20), 1'b0}) begin
            miscompares++;
            $display("FAIL adel_resume: got v=%b pc=%h inst=%h adel=%b, want v=1 pc=80 inst=%h adel=0",
                     inst_valid, inst_pc, inst, inst_adel, rom_fn(32'h20));
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'h84}) begin
            miscompares++;
            $display("FAIL adel_follow: got v=%b pc=%h, want v=1 pc=84", inst_valid, inst_pc);
        end
`else
        vectors++;
        if ({inst_valid, inst_pc, inst, inst_adel} !== {1'b1, 32'h40, rom_fn(32'h10), 1'b0}) begin
            miscompares++;
            $display("FAIL align_forced: got v=%b pc=%h inst=%h adel=%b, want v=1 pc=40 inst=%h adel=0",
                     inst_valid, inst_pc, inst, inst_adel, rom_fn(32'h10));
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst_adel} !== {1'b1, 32'h44, 1'b0}) begin
            miscompares++;
            $display("FAIL align_follow: got v=%b pc=%h adel=%b, want v=1 pc=44 adel=0",
                     inst_valid, inst_pc, inst_adel);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        inst_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h20, rom_fn(32'h8)}) begin
            miscompares++;
            $display("FAIL rst_pre_stall: got v=%b pc=%h inst=%h, want v=1 pc=20 inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h8));
        end
        // Reset and a redirect arrive together; reset must win.
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if ({inst_valid, inst_adel, rom_addr} !== {1'b0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL rst_stall_out: got v=%b adel=%b addr=%h, want v=0 adel=0 addr=0",
                     inst_valid, inst_adel, rom_addr);
        end
        rst = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0, rom_fn(32'h0)}) begin
            miscompares++;
            $display("FAIL rst_restart: got v=%b pc=%h inst=%h, want v=1 pc=0 inst=%h",
                     inst_valid, inst_pc, inst, rom_fn(32'h0));
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_align();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage sitting directly upstream of the instruction ROM: owns the program counter, drives the ROM word address and pairs each synchronous-ROM read (one-cycle latency) with its PC. It presents the fetched instruction to decode over a valid/ready handshake. It accepts a redirect (branch/jump/exception target) from downstream with zero bubble, and holds the ROM output stable while decode stalls.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetched instruction; must be word-aligned.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  reset, synchronous, active-high.
- rom_addr  out  32  ROM word address, {2'b00, pc[31:2]}; connects to the ROM address input.
- rom_data  in  32  ROM read data; reflects the rom_addr sampled at the previous edge.
- inst_valid  out  1  instruction/PC pair valid to decode.
- inst_ready  in  1  decode accepts the pair this cycle.
- inst_pc  out  32  byte PC of the presented instruction.
- inst  out  32  presented instruction.
- inst_adel  out  1  fetch address error flag on the presented instruction.
- redirect_valid  in  1  redirect request (single-cycle pulse or level; sampled each cycle).
- redirect_pc  in  32  redirect target byte PC.

## Operation
- Registers: state, fetch_pc (next PC to request), resp_pc, resp_valid, resp_adel.
- States: S_BOOT, S_RUN, S_HALT.
- advance = (state != S_HALT) && (!resp_valid || inst_ready).
- Outputs are combinational from the registers:
  - inst = resp_adel ? 32'h0 : rom_data.
  - inst_pc = resp_pc.
  - inst_adel = resp_adel.
  - inst_valid = resp_valid && !redirect_valid.
- rom_addr priority: redirect_valid → redirect_pc; else S_BOOT or advance → fetch_pc; else resp_pc (re-reads the held instruction so rom_data stays stable).
- Redirect (all states, highest priority):
  - resp_pc <= redirect_pc; resp_valid <= 1; fetch_pc <= redirect_pc + 4.
  - The instruction presented in the same cycle is discarded and never handshaken.
- S_BOOT: resp_pc <= fetch_pc; resp_valid <= 1; fetch_pc <= fetch_pc + 4; go to S_RUN.
- S_RUN with advance: same register update as S_BOOT. Without advance, all registers hold.
- S_HALT:
  - When inst_valid && inst_ready, resp_valid <= 0.
  - Stays in S_HALT until a redirect, which goes to S_RUN (or back to S_HALT per the alignment rule below).
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values: state = S_BOOT, fetch_pc = RESET_PC, resp_pc = 0, resp_valid = 0, resp_adel = 0.
  - Resulting outputs: inst_valid = 0, inst_adel = 0, rom_addr = RESET_PC>>2.
- If rst deasserts before cycle 0, then cycle 0 is S_BOOT and cycle 1 has inst_valid = 1 with inst_pc = RESET_PC.
- Streaming: one instruction per cycle while inst_ready = 1.
- Redirect latency: redirect in cycle N → target presented in cycle N+1 (zero bubble).
- Stall: inst, inst_pc and inst_valid are held bit-stable for every cycle that inst_ready = 0.
- Combinational paths: inst_ready → rom_addr, and redirect_valid/redirect_pc → rom_addr and inst_valid. The synchronous ROM registers these paths.
- rst takes precedence over redirect and over any in-flight stall; mid-stream reset restarts at S_BOOT.

## Configuration
- IFETCH_ALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets resp_adel <= 1 and state <= S_HALT.
  - The faulting pair is presented with inst = 0 and inst_adel = 1, then fetch stops until the next redirect.
  - A later aligned redirect clears resp_adel.
- IFETCH_ALIGN_CHK_EN undefined:
  - redirect_pc[1:0] is forced to 2'b00 and S_HALT is unreachable.
  - inst_adel is tied to 0.

## Structure
- Shared package ifetch_pkg holds:
  - the state enum (S_BOOT, S_RUN, S_HALT);
  - the default reset PC constant;
  - the NOP encoding 32'h0;
  - the PC increment constant 4.
- Single module; no sub-module. The ROM instance lives in the parent alongside this block.

## Test plan
- Reset then inst_ready = 1 for 4 cycles with RESET_PC = 0 → inst_pc = 0, 4, 8, 12 on consecutive cycles; inst equals ROM words 0–3.
- inst_ready = 0 for 3 cycles while inst_pc = 8 → inst_pc = 8, inst = ROM[2] and rom_addr = 2 held; on release, the next pair is 12/ROM[3].
- redirect_valid pulse with redirect_pc = 32'h40 while inst_pc = 4 is valid → inst_valid = 0 that cycle; next cycle inst_pc = 32'h40, inst = ROM[16]; following cycle inst_pc = 32'h44.
- Redirect to 32'hFFFF_FFFC → inst_pc = 32'hFFFF_FFFC, then 32'h0000_0000.
- IFETCH_ALIGN_CHK_EN, redirect_pc = 32'h42 → one pair with inst_pc = 32'h42, inst = 0, inst_adel = 1; after acceptance inst_valid stays 0; redirect to 32'h80 resumes with inst_adel = 0.
- Assert rst for 1 cycle during a stall at inst_pc = 32'h20 → inst_valid = 0 the next cycle; restart at RESET_PC.
